// File: rtl/fir_seq_pkg.sv
// Shared types for the FIR stream sequencer: the run-control FSM states.
package fir_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/fir_seq_fifo2.sv
// Two-entry FIFO feeding the FIR input stream; supports push and pop in the same cycle.
module fir_seq_fifo2 #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic [1:0]   count
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    // Storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/fir_stream_sequencer.sv
// Streams cfg_len BRAM words into the FIR core and writes its results back,
// sharing one BRAM port between the read and write paths.
module fir_stream_sequencer
    import fir_seq_pkg::*;
#(
    parameter int DW    = 32,
    parameter int AW    = 12,
    parameter int LEN_W = 16
) (
    input  logic             axis_clk,
    input  logic             axis_rst_n,
    input  logic             cfg_start,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic [AW-1:0]    cfg_src,
    input  logic [AW-1:0]    cfg_dst,
    output logic             stat_busy,
    output logic             stat_done,
    output logic             stat_err,
    output logic [LEN_W-1:0] stat_cnt,
    output logic             mem_en,
    output logic             mem_we,
    output logic [AW-1:0]    mem_addr,
    output logic [DW-1:0]    mem_wdata,
    input  logic [DW-1:0]    mem_rdata,
    output logic             ss_tvalid,
    output logic [DW-1:0]    ss_tdata,
    output logic             ss_tlast,
    input  logic             ss_tready,
    input  logic             sm_tvalid,
    input  logic [DW-1:0]    sm_tdata,
    input  logic             sm_tlast,
    output logic             sm_tready
);

    seq_state_t       state;
    logic [LEN_W-1:0] len_q;
    logic [AW-1:0]    src_q;
    logic [AW-1:0]    dst_q;
    logic [LEN_W-1:0] rd_cnt;
    logic [LEN_W-1:0] wr_cnt;

    logic             rd_vld_p1;
    logic             rd_last_p1;
    logic             out_vld_p1;
    logic [DW-1:0]    out_data_p1;

    logic [DW:0]      fifo_dout;
    logic [1:0]       fifo_cnt;
    logic             ss_pop;

    logic             active;
    logic [LEN_W:0]   wr_pend;
    logic [LEN_W:0]   last_idx;
    logic             sm_hs;
    logic             tlast_bad;
    logic             rd_issue;
    logic             wr_issue;

    assign active   = (state == RUN) || (state == DRAIN);
    assign last_idx = {1'b0, len_q - LEN_W'(1)};
    // Output index of the beat a handshake would capture now.
    assign wr_pend  = {1'b0, wr_cnt} + {{LEN_W{1'b0}}, out_vld_p1};

    assign sm_tready = active && (wr_pend < {1'b0, len_q});
    assign sm_hs     = sm_tvalid && sm_tready;
    assign tlast_bad = sm_hs && (sm_tlast != (wr_pend == last_idx));

    assign wr_issue = out_vld_p1;
    assign rd_issue = (state == RUN) && (rd_cnt < len_q) && !wr_issue &&
                      (({1'b0, fifo_cnt} + {2'b00, rd_vld_p1}) < 3'd2);

    always_comb begin
        mem_en    = rd_issue || wr_issue;
        mem_we    = wr_issue;
        mem_addr  = '0;
        mem_wdata = '0;
        if (wr_issue) begin
            mem_addr  = dst_q + AW'(wr_cnt);
            mem_wdata = out_data_p1;
        end else if (rd_issue) begin
            mem_addr  = src_q + AW'(rd_cnt);
        end
    end

    // p1: BRAM read data returns and enters the input FIFO
    fir_seq_fifo2 #(.W(DW + 1)) u_in_fifo (
        .clk       (axis_clk),
        .rst_n     (axis_rst_n),
        .push      (rd_vld_p1),
        .push_data ({rd_last_p1, mem_rdata}),
        .pop       (ss_pop),
        .pop_data  (fifo_dout),
        .count     (fifo_cnt)
    );

    assign ss_tvalid = (fifo_cnt != 2'd0);
    assign ss_tdata  = ss_tvalid ? fifo_dout[DW-1:0] : '0;
    assign ss_tlast  = ss_tvalid && fifo_dout[DW];
    assign ss_pop    = ss_tvalid && ss_tready;
    assign stat_cnt  = wr_cnt;

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state      <= IDLE;
            len_q      <= '0;
            src_q      <= '0;
            dst_q      <= '0;
            rd_cnt     <= '0;
            wr_cnt     <= '0;
            rd_vld_p1  <= 1'b0;
            rd_last_p1 <= 1'b0;
            out_vld_p1 <= 1'b0;
            stat_busy  <= 1'b0;
            stat_done  <= 1'b0;
            stat_err   <= 1'b0;
        end else begin
            rd_vld_p1  <= rd_issue;
            rd_last_p1 <= rd_issue && ({1'b0, rd_cnt} == last_idx);
            out_vld_p1 <= sm_hs;
            if (rd_issue)  rd_cnt   <= rd_cnt + LEN_W'(1);
            if (wr_issue)  wr_cnt   <= wr_cnt + LEN_W'(1);
            if (tlast_bad) stat_err <= 1'b1;
            case (state)
                IDLE: begin
                    if (cfg_start) begin
                        len_q     <= cfg_len;
                        src_q     <= cfg_src;
                        dst_q     <= cfg_dst;
                        rd_cnt    <= '0;
                        wr_cnt    <= '0;
                        stat_err  <= 1'b0;
                        stat_done <= 1'b0;
                        stat_busy <= 1'b1;
                        state     <= (cfg_len == '0) ? DONE : RUN;
                    end
                end
                RUN:   if (rd_cnt == len_q) state <= DRAIN;
                DRAIN: if (wr_cnt == len_q) state <= DONE;
                DONE: begin
                    stat_done <= 1'b1;
                    stat_busy <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // p1: result register holding one FIR output until its BRAM write
    always_ff @(posedge axis_clk) begin
        if (sm_hs) out_data_p1 <= sm_tdata;
    end

endmodule

// File: tb/tb_fir_stream_sequencer.sv
// Scoreboard bench for fir_stream_sequencer: BRAM and FIR (y=x+1) models at the negedge.
module tb_fir_stream_sequencer;

    localparam int DW    = 32;
    localparam int AW    = 12;
    localparam int LEN_W = 16;

    logic             axis_clk = 1'b0;
    logic             axis_rst_n = 1'b0;
    logic             cfg_start = 1'b0;
    logic [LEN_W-1:0] cfg_len = '0;
    logic [AW-1:0]    cfg_src = '0;
    logic [AW-1:0]    cfg_dst = '0;
    logic             stat_busy, stat_done, stat_err;
    logic [LEN_W-1:0] stat_cnt;
    logic             mem_en, mem_we;
    logic [AW-1:0]    mem_addr;
    logic [DW-1:0]    mem_wdata;
    logic [DW-1:0]    mem_rdata = '0;
    logic             ss_tvalid, ss_tlast;
    logic [DW-1:0]    ss_tdata;
    logic             ss_tready = 1'b0;
    logic             sm_tvalid = 1'b0;
    logic [DW-1:0]    sm_tdata = '0;
    logic             sm_tlast = 1'b0;
    logic             sm_tready;

    always #5 axis_clk = ~axis_clk;

    fir_stream_sequencer #(.DW(DW), .AW(AW), .LEN_W(LEN_W)) dut (
        .axis_clk   (axis_clk),
        .axis_rst_n (axis_rst_n),
        .cfg_start  (cfg_start),
        .cfg_len    (cfg_len),
        .cfg_src    (cfg_src),
        .cfg_dst    (cfg_dst),
        .stat_busy  (stat_busy),
        .stat_done  (stat_done),
        .stat_err   (stat_err),
        .stat_cnt   (stat_cnt),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .ss_tvalid  (ss_tvalid),
        .ss_tdata   (ss_tdata),
        .ss_tlast   (ss_tlast),
        .ss_tready  (ss_tready),
        .sm_tvalid  (sm_tvalid),
        .sm_tdata   (sm_tdata),
        .sm_tlast   (sm_tlast),
        .sm_tready  (sm_tready)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [DW-1:0]    bram [4096];
    logic [DW-1:0]    fir_q [$];
    logic [AW-1:0]    exp_rd_q [$];
    logic [AW+DW-1:0] exp_wr_q [$];
    int  run_len = 0, tlast_idx = 0, in_idx = 0, out_idx = 0;
    int  rdy_mode = 0, gap_en = 0, cyc = 0, acc_cnt = 0, ssv_cnt = 0;
    logic          rd_pend = 1'b0;
    logic [DW-1:0] rd_pend_data = '0;
    logic          sm_hs_prev = 1'b0;

    // Environment: BRAM with one-cycle read latency plus FIR model y = x + 1
    always @(negedge axis_clk) begin
        logic [AW+DW-1:0] e;
        cyc++;
        if (axis_rst_n) begin
            if (sm_hs_prev) begin
                sm_tvalid = 1'b0;
                sm_tlast  = 1'b0;
                out_idx++;
            end
            if (!sm_tvalid && fir_q.size() != 0 && (gap_en == 0 || $urandom_range(0, 2) != 0)) begin
                sm_tdata  = fir_q.pop_front() + DW'(1);
                sm_tlast  = (out_idx == tlast_idx);
                sm_tvalid = 1'b1;
            end
            ss_tready = (rdy_mode == 0) ? 1'b1 : (cyc % 3 == 0);

            mem_rdata = rd_pend ? rd_pend_data : '0;
            rd_pend   = 1'b0;
            if (mem_en) acc_cnt++;
            if (mem_en && !mem_we) begin
                if (exp_rd_q.size() == 0) check("rd_unexpected", 64'(mem_addr), 64'hFFFF);
                else check("rd_addr", 64'(mem_addr), 64'(exp_rd_q.pop_front()));
                rd_pend_data = bram[mem_addr];
                rd_pend      = 1'b1;
            end
            if (mem_we) begin
                check("wr_with_en", 64'(mem_en), 64'd1);
                if (exp_wr_q.size() == 0) check("wr_unexpected", 64'(mem_addr), 64'hFFFF);
                else begin
                    e = exp_wr_q.pop_front();
                    check("wr_addr", 64'(mem_addr), 64'(e[AW+DW-1:DW]));
                    check("wr_data", 64'(mem_wdata), 64'(e[DW-1:0]));
                end
                bram[mem_addr] = mem_wdata;
            end
            if (ss_tvalid) ssv_cnt++;
            if (ss_tvalid && ss_tready) begin
                check("ss_tlast", 64'(ss_tlast), 64'(in_idx == run_len - 1));
                fir_q.push_back(ss_tdata);
                in_idx++;
            end
            sm_hs_prev = sm_tvalid && sm_tready;
        end
    end

    logic [DW-1:0] xin [$];

    task automatic start_job(input int len, input logic [AW-1:0] src, input logic [AW-1:0] dst,
                             input int tl, input int rmode, input int gap);
        logic [DW-1:0] v;
        logic [AW-1:0] a;
        run_len = len; tlast_idx = tl; rdy_mode = rmode; gap_en = gap;
        in_idx = 0; out_idx = 0; acc_cnt = 0; ssv_cnt = 0;
        xin.delete();
        for (int i = 0; i < len; i++) begin
            v = $urandom;
            a = src + AW'(i);
            bram[a] = v;
            xin.push_back(v);
            exp_rd_q.push_back(a);
        end
        for (int i = 0; i < len; i++) exp_wr_q.push_back({dst + AW'(i), xin[i] + DW'(1)});
        @(negedge axis_clk);
        cfg_len = LEN_W'(len); cfg_src = src; cfg_dst = dst; cfg_start = 1'b1;
        @(negedge axis_clk);
        cfg_start = 1'b0;
        check("busy_after_start", 64'(stat_busy), 64'd1);
        check("done_cleared", 64'(stat_done), 64'd0);
    endtask

    task automatic finish_job(input int len, input logic [AW-1:0] dst, input bit exp_err, input string nm);
        int n = 0;
        while (stat_busy && n < 3000) begin
            @(negedge axis_clk);
            n++;
        end
        if (n >= 3000) check({nm, "_timeout"}, 64'(n), 64'd0);
        check({nm, "_done"}, 64'(stat_done), 64'd1);
        check({nm, "_cnt"}, 64'(stat_cnt), 64'(len));
        check({nm, "_err"}, 64'(stat_err), 64'(exp_err));
        check({nm, "_rd_left"}, 64'(exp_rd_q.size()), 64'd0);
        check({nm, "_wr_left"}, 64'(exp_wr_q.size()), 64'd0);
        for (int i = 0; i < len; i++)
            check({nm, "_bram"}, 64'(bram[dst + AW'(i)]), 64'(xin[i] + DW'(1)));
    endtask

    task automatic wait_in(input int k);
        int n = 0;
        while (in_idx < k && n < 500) begin
            @(negedge axis_clk);
            n++;
        end
        if (n >= 500) check("wait_in_timeout", 64'(in_idx), 64'(k));
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, "_ctrl"}, 64'({stat_busy, stat_done, stat_err, stat_cnt, mem_en, mem_we,
                                   mem_addr, ss_tvalid, ss_tlast, sm_tready}), 64'd0);
        check({nm, "_data"}, {ss_tdata, mem_wdata}, 64'd0);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) bram[i] = '0;
        repeat (3) @(negedge axis_clk);
        check_all_zero("reset");
        axis_rst_n = 1'b1;
        repeat (2) @(negedge axis_clk);

        start_job(8, 12'h100, 12'h200, 7, 0, 0);
        finish_job(8, 12'h200, 1'b0, "t1_basic");

        start_job(8, 12'h100, 12'h200, 7, 1, 1);
        finish_job(8, 12'h200, 1'b0, "t2_backpr");

        start_job(6, 12'h400, 12'h400, 5, 1, 1);
        finish_job(6, 12'h400, 1'b0, "t2_inplace");

        start_job(0, 12'h000, 12'h000, -1, 0, 0);
        @(negedge axis_clk);
        check("t3_busy_cleared", 64'(stat_busy), 64'd0);
        finish_job(0, 12'h000, 1'b0, "t3_len0");
        check("t3_no_mem", 64'(acc_cnt), 64'd0);
        check("t3_no_ssv", 64'(ssv_cnt), 64'd0);

        start_job(4, 12'hFFE, 12'h300, 3, 0, 0);
        finish_job(4, 12'h300, 1'b0, "t4_wrap");

        start_job(8, 12'h040, 12'h080, 7, 0, 0);
        wait_in(1);
        cfg_len = 16'd2; cfg_src = 12'h500; cfg_dst = 12'h600; cfg_start = 1'b1;
        @(negedge axis_clk);
        cfg_start = 1'b0;
        check("t5_restart_ignored", 64'(stat_busy), 64'd1);
        wait_in(3);
        #2 axis_rst_n = 1'b0;
        #1 check_all_zero("t5_async_reset");
        fir_q.delete(); exp_rd_q.delete(); exp_wr_q.delete();
        sm_tvalid = 1'b0; sm_tlast = 1'b0; sm_tdata = '0;
        sm_hs_prev = 1'b0; rd_pend = 1'b0; mem_rdata = '0;
        repeat (3) @(negedge axis_clk);
        check_all_zero("t5_held_reset");
        axis_rst_n = 1'b1;
        @(negedge axis_clk);
        start_job(4, 12'h040, 12'h0C0, 3, 1, 1);
        finish_job(4, 12'h0C0, 1'b0, "t5_after_reset");

        start_job(4, 12'h010, 12'h020, 2, 0, 0);
        finish_job(4, 12'h020, 1'b1, "t6_tlast_err");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got time %0t expected completion", $time);
        $fatal(1);
    end

endmodule
